slice_bit_fifo: RTL and testbench

Per-slice bitstream buffer that sits directly downstream of the slice demultiplexer, one instance per slice lane. It absorbs the 256-bit, byte-aligned words delivered for one slice, with no back-pressure, and stores them in a word FIFO. It presents a 256-bit MSB-first bit window to the slice decoder front end, which consumes a variable number of bits (0..256) per cycle.

---
 rtl/slice_bit_fifo.sv | 167 ++++++++++++++++
 tb/tb_slice_bit_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_bit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : slice_bit_fifo
//  Description : Per-slice bitstream buffer. Absorbs byte-aligned 256-bit
//                words from one slice demux lane into a word FIFO and
//                presents a 256-bit MSB-first bit window to the slice
//                decoder, which consumes 0..256 bits per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module slice_bit_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [255:0]               in_data,
    input  logic                       in_sof,
    output logic [255:0]               out_data,
    output logic                       out_valid,
    input  logic                       shift_en,
    input  logic [8:0]                 shift_amt,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_pw = c_aw + 1;

    // Word storage and pointers; the pointer MSB separates full from empty.
    logic [255:0]    r_mem [DEPTH];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;

    // Staging slots: S0 holds the word containing the next stream bit,
    // S1 the word after it.
    logic [255:0]    r_s0;
    logic [255:0]    r_s1;
    logic            r_v0;
    logic            r_v1;
    logic [7:0]      r_bit_pos;
    logic            r_overflow;

    logic [255:0]    w_in_word;
    logic [255:0]    w_head;
    logic [c_pw-1:0] w_level;
    logic            w_empty;
    logic            w_full;
    logic            w_sof;
    logic            w_consume;
    logic [9:0]      w_sum;
    logic            w_advance;
    logic            w_reload_pop;
    logic            w_fill0;
    logic            w_fill1;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [511:0]    w_cat_sh;

    // Byte-reverse the incoming word so stream byte 0 sits in the top byte.
    for (genvar k = 0; k < 32; k++) begin : g_rev
        assign w_in_word[255-8*k -: 8] = in_data[8*k +: 8];
    end

    assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == c_pw'(DEPTH));
    assign w_sof   = in_valid & in_sof;

    // A shift only counts when the window is complete.
    assign w_consume    = shift_en & r_v0 & r_v1;
    assign w_sum        = {2'b00, r_bit_pos} + {1'b0, shift_amt};
    assign w_advance    = w_consume & (|w_sum[9:8]);

    // Reload on slot advance wins; otherwise refill the lowest empty slot.
    // The emptiness test uses the registered level, so a word written this
    // cycle is never forwarded into staging.
    assign w_reload_pop = w_advance & ~w_empty;
    assign w_fill0      = ~w_advance & ~r_v0 & ~w_empty;
    assign w_fill1      = ~w_advance & r_v0 & ~r_v1 & ~w_empty;
    assign w_pop        = w_reload_pop | w_fill0 | w_fill1;

    // A full FIFO still accepts a word when a pop frees a slot this cycle.
    assign w_push = in_valid & (~w_full | w_pop);
    assign w_drop = in_valid & w_full & ~w_pop;

    // Window: 256 bits of {S0,S1} starting at bit_pos from the MSB.
    assign w_cat_sh  = {r_s0, r_s1} << r_bit_pos;
    assign out_data  = w_cat_sh[511:256];
    assign out_valid = r_v0 & r_v1;
    assign level     = w_level;
    assign overflow  = r_overflow;

    // FIFO memory write; a start-of-frame word always lands in entry 0.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (w_sof) begin
                r_mem[0] <= w_in_word;
            end else if (w_push) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= w_in_word;
            end
        end
    end

    // Pointers, staging slots, bit position and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_s0       <= '0;
            r_s1       <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_bit_pos  <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_bit_pos  <= '0;
            r_overflow <= 1'b0;
        end else if (w_sof) begin
            // Restart the stream: the new word becomes the only FIFO entry
            // and any shift or refill this cycle is discarded.
            r_wr_ptr   <= c_pw'(1);
            r_rd_ptr   <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_bit_pos  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_consume) begin
                // sum is below 512, so its low byte is the new offset
                // whether or not the slot advances.
                r_bit_pos <= w_sum[7:0];
                if (w_advance) begin
                    r_s0 <= r_s1;
                    if (!w_empty) begin
                        r_s1 <= w_head;
                    end else begin
                        r_v1 <= 1'b0;
                    end
                end
            end else if (w_fill0) begin
                r_s0 <= w_head;
                r_v0 <= 1'b1;
            end else if (w_fill1) begin
                r_s1 <= w_head;
                r_v1 <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slice_bit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slice_bit_fifo
//  Description : Self-checking bench for slice_bit_fifo (DEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_slice_bit_fifo;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [255:0] in_data = '0;
    logic         in_sof = 1'b0;
    logic [255:0] out_data;
    logic         out_valid;
    logic         shift_en = 1'b0;
    logic [8:0]   shift_amt = '0;
    logic [2:0]   level;
    logic         overflow;

    int total = 0;
    int bad   = 0;
    logic [255:0] sb_q[$];

    always #5 clk = ~clk;

    slice_bit_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .out_data(out_data), .out_valid(out_valid),
        .shift_en(shift_en), .shift_amt(shift_amt),
        .level(level), .overflow(overflow)
    );

    // Stream word whose byte k equals base+k.
    function automatic logic [255:0] mk_in(input logic [7:0] base);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    // Stream word as it appears MSB-first in the window.
    function automatic logic [255:0] to_msb(input logic [255:0] w);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[255-8*k -: 8] = w[8*k +: 8];
        return r;
    endfunction

    function automatic logic [255:0] win(input logic [255:0] a, input logic [255:0] b, input int pos);
        logic [511:0] c;
        c = {a, b} << pos;
        return c[511:256];
    endfunction

    function automatic logic [255:0] rnd_word();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_sof = 0; in_data = '0; shift_en = 0; shift_amt = '0;
    endtask

    task automatic do_flush();
        idle_inputs(); flush = 1; tick(); flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (out_data !== 256'd0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        do_flush();
        in_valid = 1; in_sof = 1; in_data = mk_in(8'h00); tick();
        total++; if (level !== 3'd1) begin bad++; $display("FAIL basic_level_w0 got=%0d want=1", level); end
        in_sof = 0; in_data = mk_in(8'h20); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
        in_valid = 0; tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        total++; if (out_data[255:248] !== 8'h00 || out_data[7:0] !== 8'h1F)
            begin bad++; $display("FAIL basic_window got=%h/%h want=00/1f", out_data[255:248], out_data[7:0]); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL basic_level got=%0d want=0", level); end
        shift_en = 1; shift_amt = 9'd8; tick();
        total++; if (out_data[255:248] !== 8'h01 || out_data[7:0] !== 8'h20)
            begin bad++; $display("FAIL shift8_window got=%h/%h want=01/20", out_data[255:248], out_data[7:0]); end
        shift_amt = 9'd248; tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL advance_valid got=%b want=0", out_valid); end
        total++; if (out_data[255:248] !== 8'h20) begin bad++; $display("FAIL advance_top got=%h want=20", out_data[255:248]); end
        shift_en = 0; in_valid = 1; in_data = mk_in(8'h40); tick();
        in_valid = 0;
        total++; if (level !== 3'd1) begin bad++; $display("FAIL w2_level got=%0d want=1", level); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL w2_valid got=%b want=1", out_valid); end
        total++; if (out_data !== to_msb(mk_in(8'h20))) begin bad++; $display("FAIL w2_window got=%h want=%h", out_data, to_msb(mk_in(8'h20))); end
        idle_inputs();
    endtask

    task automatic test_boundary();
        logic [255:0] a, b, c, d;
        a = rnd_word(); b = rnd_word(); c = rnd_word(); d = rnd_word();
        do_flush();
        in_valid = 1; in_sof = 1; in_data = a; tick();
        in_sof = 0; in_data = b; tick();
        in_data = c; tick();
        in_valid = 0; tick();
        total++; if (out_data !== to_msb(a)) begin bad++; $display("FAIL bnd_start got=%h want=%h", out_data, to_msb(a)); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL bnd_level got=%0d want=1", level); end
        shift_en = 1; shift_amt = 9'd0; tick();
        total++; if (out_data !== to_msb(a)) begin bad++; $display("FAIL bnd_shift0 got=%h want=%h", out_data, to_msb(a)); end
        shift_amt = 9'd255; tick();
        total++; if (out_data !== win(to_msb(a), to_msb(b), 255))
            begin bad++; $display("FAIL bnd_shift255 got=%h want=%h", out_data, win(to_msb(a), to_msb(b), 255)); end
        shift_amt = 9'd256; tick();
        total++; if (out_data !== win(to_msb(b), to_msb(c), 255))
            begin bad++; $display("FAIL bnd_sum511 got=%h want=%h", out_data, win(to_msb(b), to_msb(c), 255)); end
        total++; if (out_valid !== 1'b1 || level !== 3'd0)
            begin bad++; $display("FAIL bnd_sum511_state got=%b/%0d want=1/0", out_valid, level); end
        shift_amt = 9'd1; tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bnd_sum256_valid got=%b want=0", out_valid); end
        total++; if (out_data !== to_msb(c)) begin bad++; $display("FAIL bnd_sum256_data got=%h want=%h", out_data, to_msb(c)); end
        shift_amt = 9'd8; tick();
        total++; if (out_data !== to_msb(c)) begin bad++; $display("FAIL bnd_invalid_shift got=%h want=%h", out_data, to_msb(c)); end
        shift_en = 0; in_valid = 1; in_data = d; tick();
        in_valid = 0; tick();
        total++; if (out_valid !== 1'b1 || out_data !== to_msb(c))
            begin bad++; $display("FAIL bnd_refill got=%b/%h want=1/%h", out_valid, out_data, to_msb(c)); end
        idle_inputs();
    endtask

    task automatic test_overflow();
        do_flush();
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            in_sof = (i == 0); in_data = mk_in(8'(i * 37)); tick();
        end
        in_sof = 0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_full_level got=%0d want=4", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
        total++; if (out_valid !== 1'b1 || out_data !== to_msb(mk_in(8'd0)))
            begin bad++; $display("FAIL ovf_window got=%b/%h want=1/%h", out_valid, out_data, to_msb(mk_in(8'd0))); end
        shift_en = 1; shift_amt = 9'd256; in_data = mk_in(8'(6 * 37)); tick();
        total++; if (level !== 3'd4 || overflow !== 1'b0)
            begin bad++; $display("FAIL ovf_push_pop got=%0d/%b want=4/0", level, overflow); end
        total++; if (out_data !== to_msb(mk_in(8'd37))) begin bad++; $display("FAIL ovf_push_pop_data got=%h want=%h", out_data, to_msb(mk_in(8'd37))); end
        shift_en = 0; in_data = mk_in(8'(7 * 37)); tick();
        total++; if (level !== 3'd4 || overflow !== 1'b1)
            begin bad++; $display("FAIL ovf_drop got=%0d/%b want=4/1", level, overflow); end
        in_sof = 1; in_data = mk_in(8'h99); tick();
        total++; if (overflow !== 1'b0 || level !== 3'd1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL ovf_sof got=%b/%0d/%b want=0/1/0", overflow, level, out_valid); end
        idle_inputs(); tick(); tick();
        total++; if (out_valid !== 1'b0 || out_data !== to_msb(mk_in(8'h99)))
            begin bad++; $display("FAIL ovf_sof_stage got=%b/%h want=0/%h", out_valid, out_data, to_msb(mk_in(8'h99))); end
    endtask

    task automatic test_back_to_back();
        bit seen_valid;
        int consumed;
        seen_valid = 0; consumed = 0;
        sb_q.delete();
        do_flush();
        for (int cyc = 0; cyc < 60; cyc++) begin
            in_valid = (cyc < 40);
            in_sof   = (cyc == 0);
            in_data  = rnd_word();
            if (in_valid) sb_q.push_back(to_msb(in_data));
            if (out_valid) seen_valid = 1;
            if (seen_valid && cyc < 40) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_gap cyc=%0d got=%b want=1", cyc, out_valid); end
            end
            shift_en  = out_valid;
            shift_amt = 9'd256;
            if (out_valid) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_word got=%h want=none", out_data);
                end else begin
                    if (out_data !== sb_q[0]) begin bad++; $display("FAIL b2b_order cyc=%0d got=%h want=%h", cyc, out_data, sb_q[0]); end
                    void'(sb_q.pop_front());
                end
                consumed++;
            end
            tick();
        end
        idle_inputs();
        total++; if (consumed !== 39) begin bad++; $display("FAIL b2b_count got=%0d want=39", consumed); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b want=0", overflow); end
        total++; if (out_valid !== 1'b0 || sb_q.size() != 1) begin bad++; $display("FAIL b2b_tail got=%b/%0d want=0/1", out_valid, sb_q.size()); end
        else if (out_data !== sb_q[0]) begin bad++; $display("FAIL b2b_last got=%h want=%h", out_data, sb_q[0]); end
    endtask

    task automatic test_flush_sof();
        do_flush();
        in_valid = 1; in_sof = 1; in_data = rnd_word(); tick();
        in_sof = 0; in_data = rnd_word(); tick();
        in_sof = 1; flush = 1; in_data = rnd_word(); tick();
        total++; if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0)
            begin bad++; $display("FAIL flush_sof got=%0d/%b/%b want=0/0/0", level, out_valid, overflow); end
        idle_inputs(); tick();
        total++; if (level !== 3'd0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL flush_sof_after got=%0d/%b want=0/0", level, out_valid); end
    endtask

    task automatic test_async_reset();
        do_flush();
        in_valid = 1; in_sof = 1; in_data = rnd_word(); tick();
        in_sof = 0; in_data = rnd_word(); tick();
        in_data = rnd_word(); tick();
        in_valid = 0; tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b want=1", out_valid); end
        #2 rst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 || out_data !== 256'd0)
            begin bad++; $display("FAIL arst got=%b/%0d/%b/%h want=0/0/0/0", out_valid, level, overflow, out_data); end
        @(posedge clk); #1 rst_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_overflow();
        test_back_to_back();
        test_flush_sof();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
